otter_cu_fsm: RTL and testbench
===============================

Name: otter_cu_fsm

Overview:
Multicycle control unit for the OTTER RV32I core with 1-cycle memory. It sequences fetch, execute, load writeback and interrupt entry. It drives every datapath select, including rf_wr_sel, which feeds the register-file writeback 4:1 mux. The FSM and a combinational instruction decoder live together in this block.

Parameters:
None. Encodings are fixed in otter_pkg.

Ports:
CLK  in  1  core clock; all state updates on the rising edge
RST  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]
func3  in  3  IR[14:12]
func7_b5  in  1  IR[30]
br_eq, br_lt, br_ltu  in  1 each  branch condition generator results
intr  in  1  interrupt request, already masked by MIE
core_rst  out  1  reset strobe to PC and CSR file
pc_write  out  1  PC register load enable
reg_write  out  1  register-file write enable
mem_rden1  out  1  instruction read enable
mem_rden2  out  1  data read enable
mem_we2  out  1  data write enable
csr_we  out  1  CSR write enable
int_taken  out  1  interrupt entry strobe to CSR file
mret_exec  out  1  MRET strobe to CSR file
pc_source  out  3  0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC
alu_src_a  out  1  0 rs1, 1 U-imm
alu_src_b  out  2  0 rs2, 1 I-imm, 2 S-imm, 3 PC
rf_wr_sel  out  2  0 PC+4, 1 CSR rd, 2 DOUT2, 3 ALU result
alu_fun  out  4  ALU operation

Behaviour:
- State register. States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR. RST high at a rising edge forces ST_INIT. This applies mid-instruction too; no partial write survives.
- Output timing. Outputs are combinational from the current state plus decode. Every strobe is 0 except as listed below. Select outputs default to 0 when not used.
- ST_INIT: core_rst=1. Next state is ST_FETCH.
- ST_FETCH: mem_rden1=1. Next state is ST_EXEC. The IR is valid in ST_EXEC because memory latency is 1 cycle.
- ST_EXEC, load (0000011):
  - mem_rden2=1, alu_src_b=1, alu_fun=ADD.
  - No pc_write. Next state is ST_WB.
- ST_EXEC, all other opcodes: pc_write=1. Next state is ST_INTR if intr, else ST_FETCH. Per opcode:
  - OP (0110011): reg_write=1, rf_wr_sel=3, alu_fun={func7_b5,func3}.
  - OP-IMM (0010011): reg_write=1, rf_wr_sel=3, alu_src_b=1. alu_fun={func7_b5,func3} when func3==101, else {0,func3}.
  - LUI: reg_write=1, rf_wr_sel=3, alu_src_a=1, alu_fun=1001 (pass A).
  - AUIPC: reg_write=1, rf_wr_sel=3, alu_src_a=1, alu_src_b=3, alu_fun=ADD.
  - JAL: reg_write=1, rf_wr_sel=0, pc_source=3.
  - JALR: reg_write=1, rf_wr_sel=0, pc_source=1.
  - STORE: mem_we2=1, alu_src_b=2, alu_fun=ADD.
  - BRANCH: pc_source=2 if taken, else 0. Taken per func3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu. Other func3 values are not taken.
  - SYSTEM, func3==000 (MRET): mret_exec=1, pc_source=5.
  - SYSTEM, func3!=000 (CSRRW): csr_we=1, reg_write=1, rf_wr_sel=1.
  - Unknown opcode: NOP. pc_write=1, pc_source=0, no other writes.
- ST_WB: reg_write=1, rf_wr_sel=2, pc_write=1, pc_source=0. Next state is ST_INTR if intr, else ST_FETCH.
- ST_INTR: int_taken=1, pc_write=1, pc_source=4. Next state is ST_FETCH unconditionally, even if intr stays high.
- Interrupt sampling. intr is sampled only at instruction completion (end of ST_EXEC or ST_WB). intr asserted during ST_FETCH or ST_INTR is ignored until the next completion.
- Reset values (cycle after an RST edge): state ST_INIT, core_rst=1. All other strobes 0, all selects 0.
- rf_wr_sel never takes a value outside 0..3. The downstream mux default (ALU) is therefore never relied upon for illegal values.

Decomposition:
- otter_pkg holds the following; FSM and decoder share it:
  - opcode_t enum
  - state_t enum
  - pc_source, alu_src_b and rf_wr_sel encodings as localparams
  - ALU_ADD and ALU_LUI constants
- One sub-module, otter_dcdr, is combinational. It maps opcode, func3, func7_b5 and the branch flags to selects and alu_fun.
- otter_cu_fsm owns the state register and strobes, and instantiates otter_dcdr.

Test Plan:
- Reset: hold RST 2 cycles, then release. Required: core_rst=1 for exactly the first cycle after release, then ST_FETCH with mem_rden1=1.
- ADD: opcode 0110011, func3 000, func7_b5 0. Required: EXEC cycle has reg_write=1, rf_wr_sel=3, alu_fun=0000, pc_write=1; next cycle is FETCH.
- LW: opcode 0000011. Required: EXEC has mem_rden2=1 and pc_write=0. WB has reg_write=1, rf_wr_sel=2, pc_write=1. Total 3 cycles.
- BNE with br_eq=1: pc_source=0. Same instruction with br_eq=0: pc_source=2. Both cases: reg_write=0.
- intr=1 during EXEC of ADDI: next state is INTR with int_taken=1, pc_source=4, pc_write=1, then FETCH. intr=1 held through FETCH only: no entry.
- RST asserted during WB of LW: next cycle is INIT with reg_write=0, pc_write=0.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER multicycle control unit: opcodes, FSM states
// and the datapath select values driven by the FSM and the decoder.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } state_t;

  localparam logic [2:0] PC_SRC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_SRC_JALR   = 3'd1;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
  localparam logic [2:0] PC_SRC_JAL    = 3'd3;
  localparam logic [2:0] PC_SRC_MTVEC  = 3'd4;
  localparam logic [2:0] PC_SRC_MEPC   = 3'd5;

  localparam logic       SRCA_RS1  = 1'b0;
  localparam logic       SRCA_UIMM = 1'b1;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IIMM = 2'd1;
  localparam logic [1:0] SRCB_SIMM = 2'd2;
  localparam logic [1:0] SRCB_PC   = 2'd3;

  localparam logic [1:0] RF_PC4   = 2'd0;
  localparam logic [1:0] RF_CSR   = 2'd1;
  localparam logic [1:0] RF_DOUT2 = 2'd2;
  localparam logic [1:0] RF_ALU   = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  // Unused func3 codes (010, 011) never take the branch.
  function automatic logic branch_taken(input logic [2:0] func3, input logic br_eq,
                                        input logic br_lt, input logic br_ltu);
    case (func3)
      3'b000:  branch_taken = br_eq;
      3'b001:  branch_taken = !br_eq;
      3'b100:  branch_taken = br_lt;
      3'b101:  branch_taken = !br_lt;
      3'b110:  branch_taken = br_ltu;
      3'b111:  branch_taken = !br_ltu;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control bundle between the OTTER control unit (master) and the datapath
// (slave): instruction fields and flags in, strobes and selects out.
interface otter_cu_fsm_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_b5;
  logic       br_eq;
  logic       br_lt;
  logic       br_ltu;
  logic       intr;

  logic       core_rst;
  logic       pc_write;
  logic       reg_write;
  logic       mem_rden1;
  logic       mem_rden2;
  logic       mem_we2;
  logic       csr_we;
  logic       int_taken;
  logic       mret_exec;
  logic [2:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] rf_wr_sel;
  logic [3:0] alu_fun;

  modport master (
    input  opcode, func3, func7_b5, br_eq, br_lt, br_ltu, intr,
    output core_rst, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
           csr_we, int_taken, mret_exec, pc_source, alu_src_a, alu_src_b,
           rf_wr_sel, alu_fun
  );

  modport slave (
    output opcode, func3, func7_b5, br_eq, br_lt, br_ltu, intr,
    input  core_rst, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
           csr_we, int_taken, mret_exec, pc_source, alu_src_a, alu_src_b,
           rf_wr_sel, alu_fun
  );
endinterface

// File: rtl/otter_dcdr.sv
// Combinational instruction decoder: maps opcode/func fields and branch flags
// to datapath selects and ALU function. Strobes are owned by the FSM.
module otter_dcdr
  import otter_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic       func7_b5_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       br_ltu_i,
  output logic [2:0] pc_source_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] rf_wr_sel_o,
  output logic [3:0] alu_fun_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    pc_source_o = PC_SRC_PLUS4;
    alu_src_a_o = SRCA_RS1;
    alu_src_b_o = SRCB_RS2;
    rf_wr_sel_o = RF_PC4;
    alu_fun_o   = ALU_ADD;

    case (opcode_t'(opcode_i))
      OPC_OP: begin
        rf_wr_sel_o = RF_ALU;
        alu_fun_o   = {func7_b5_i, func3_i};
      end
      OPC_OP_IMM: begin
        rf_wr_sel_o = RF_ALU;
        alu_src_b_o = SRCB_IIMM;
        // IR[30] is only an opcode bit for shift-right immediates.
        alu_fun_o   = (func3_i == 3'b101) ? {func7_b5_i, func3_i} : {1'b0, func3_i};
      end
      OPC_LUI: begin
        rf_wr_sel_o = RF_ALU;
        alu_src_a_o = SRCA_UIMM;
        alu_fun_o   = ALU_LUI;
      end
      OPC_AUIPC: begin
        rf_wr_sel_o = RF_ALU;
        alu_src_a_o = SRCA_UIMM;
        alu_src_b_o = SRCB_PC;
      end
      OPC_JAL:    pc_source_o = PC_SRC_JAL;
      OPC_JALR:   pc_source_o = PC_SRC_JALR;
      OPC_STORE:  alu_src_b_o = SRCB_SIMM;
      OPC_LOAD:   alu_src_b_o = SRCB_IIMM;
      OPC_BRANCH: pc_source_o = branch_taken(func3_i, br_eq_i, br_lt_i, br_ltu_i)
                                ? PC_SRC_BRANCH : PC_SRC_PLUS4;
      OPC_SYSTEM: begin
        if (func3_i == 3'b000) pc_source_o = PC_SRC_MEPC;
        else                   rf_wr_sel_o = RF_CSR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: sequences init, fetch, execute, load
// writeback and interrupt entry; selects come from otter_dcdr in execute.
module otter_cu_fsm
  import otter_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  otter_cu_fsm_if.master cu
);

  state_t     state_q, state_d;
  logic [2:0] dec_pc_source;
  logic       dec_alu_src_a;
  logic [1:0] dec_alu_src_b;
  logic [1:0] dec_rf_wr_sel;
  logic [3:0] dec_alu_fun;

  otter_dcdr u_dcdr (
    .opcode_i    (cu.opcode),
    .func3_i     (cu.func3),
    .func7_b5_i  (cu.func7_b5),
    .br_eq_i     (cu.br_eq),
    .br_lt_i     (cu.br_lt),
    .br_ltu_i    (cu.br_ltu),
    .pc_source_o (dec_pc_source),
    .alu_src_a_o (dec_alu_src_a),
    .alu_src_b_o (dec_alu_src_b),
    .rf_wr_sel_o (dec_rf_wr_sel),
    .alu_fun_o   (dec_alu_fun)
  );

  // NOTE: state register uses non-blocking assignment; all combinational
  // logic lives in the always_comb below.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cu.core_rst  = 1'b0;
    cu.pc_write  = 1'b0;
    cu.reg_write = 1'b0;
    cu.mem_rden1 = 1'b0;
    cu.mem_rden2 = 1'b0;
    cu.mem_we2   = 1'b0;
    cu.csr_we    = 1'b0;
    cu.int_taken = 1'b0;
    cu.mret_exec = 1'b0;
    cu.pc_source = PC_SRC_PLUS4;
    cu.alu_src_a = SRCA_RS1;
    cu.alu_src_b = SRCB_RS2;
    cu.rf_wr_sel = RF_PC4;
    cu.alu_fun   = ALU_ADD;

    case (state_q)
      ST_INIT: begin
        cu.core_rst = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_FETCH: begin
        cu.mem_rden1 = 1'b1;
        state_d      = ST_EXEC;
      end
      ST_EXEC: begin
        cu.pc_source = dec_pc_source;
        cu.alu_src_a = dec_alu_src_a;
        cu.alu_src_b = dec_alu_src_b;
        cu.rf_wr_sel = dec_rf_wr_sel;
        cu.alu_fun   = dec_alu_fun;
        if (opcode_t'(cu.opcode) == OPC_LOAD) begin
          // PC holds until writeback so a load completes as one instruction.
          cu.mem_rden2 = 1'b1;
          state_d      = ST_WB;
        end else begin
          cu.pc_write = 1'b1;
          state_d     = cu.intr ? ST_INTR : ST_FETCH;
          case (opcode_t'(cu.opcode))
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
              cu.reg_write = 1'b1;
            OPC_STORE: cu.mem_we2 = 1'b1;
            OPC_SYSTEM: begin
              if (cu.func3 == 3'b000) begin
                cu.mret_exec = 1'b1;
              end else begin
                cu.csr_we    = 1'b1;
                cu.reg_write = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WB: begin
        cu.reg_write = 1'b1;
        cu.rf_wr_sel = RF_DOUT2;
        cu.pc_write  = 1'b1;
        state_d      = cu.intr ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        cu.int_taken = 1'b1;
        cu.pc_write  = 1'b1;
        cu.pc_source = PC_SRC_MTVEC;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Scoreboard bench for otter_cu_fsm: a per-cycle behavioural model predicts
// every control output; a monitor compares the DUT against queued predictions.
module tb_otter_cu_fsm;

  logic CLK = 1'b0;
  logic RST;

  otter_cu_fsm_if bus ();

  otter_cu_fsm dut (
    .CLK (CLK),
    .RST (RST),
    .cu  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       core_rst;
    logic       pc_write;
    logic       reg_write;
    logic       mem_rden1;
    logic       mem_rden2;
    logic       mem_we2;
    logic       csr_we;
    logic       int_taken;
    logic       mret_exec;
    logic [2:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] rf_wr_sel;
    logic [3:0] alu_fun;
  } ctrl_t;

  typedef struct {
    ctrl_t exp;
    string tag;
  } sb_item_t;

  sb_item_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Phase of the instruction the model believes the core is in.
  localparam int PH_INIT = 0, PH_FETCH = 1, PH_EXEC = 2, PH_WB = 3, PH_INTR = 4;
  int phase = PH_INIT;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  function automatic ctrl_t observed();
    ctrl_t c;
    c.core_rst  = bus.core_rst;
    c.pc_write  = bus.pc_write;
    c.reg_write = bus.reg_write;
    c.mem_rden1 = bus.mem_rden1;
    c.mem_rden2 = bus.mem_rden2;
    c.mem_we2   = bus.mem_we2;
    c.csr_we    = bus.csr_we;
    c.int_taken = bus.int_taken;
    c.mret_exec = bus.mret_exec;
    c.pc_source = bus.pc_source;
    c.alu_src_a = bus.alu_src_a;
    c.alu_src_b = bus.alu_src_b;
    c.rf_wr_sel = bus.rf_wr_sel;
    c.alu_fun   = bus.alu_fun;
    return c;
  endfunction

  function automatic ctrl_t exec_expect(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic eq,
                                        input logic lt, input logic ltu);
    ctrl_t c;
    logic  taken;
    c = '0;
    c.pc_write = (op != OP_LOAD);
    case (op)
      7'b0110011: begin c.reg_write = 1; c.rf_wr_sel = 3; c.alu_fun = {f7, f3}; end
      7'b0010011: begin
        c.reg_write = 1; c.rf_wr_sel = 3; c.alu_src_b = 1;
        c.alu_fun = (f3 == 3'b101) ? {f7, f3} : {1'b0, f3};
      end
      7'b0110111: begin c.reg_write = 1; c.rf_wr_sel = 3; c.alu_src_a = 1; c.alu_fun = 4'b1001; end
      7'b0010111: begin c.reg_write = 1; c.rf_wr_sel = 3; c.alu_src_a = 1; c.alu_src_b = 3; end
      7'b1101111: begin c.reg_write = 1; c.pc_source = 3; end
      7'b1100111: begin c.reg_write = 1; c.pc_source = 1; end
      7'b0100011: begin c.mem_we2 = 1; c.alu_src_b = 2; end
      7'b0000011: begin c.mem_rden2 = 1; c.alu_src_b = 1; end
      7'b1100011: begin
        case (f3)
          3'b000:  taken = eq;
          3'b001:  taken = !eq;
          3'b100:  taken = lt;
          3'b101:  taken = !lt;
          3'b110:  taken = ltu;
          3'b111:  taken = !ltu;
          default: taken = 1'b0;
        endcase
        c.pc_source = taken ? 3'd2 : 3'd0;
      end
      7'b1110011: begin
        if (f3 == 3'b000) begin c.mret_exec = 1; c.pc_source = 5; end
        else begin c.csr_we = 1; c.reg_write = 1; c.rf_wr_sel = 1; end
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t model_expect(input int ph, input logic [6:0] op,
                                         input logic [2:0] f3, input logic f7,
                                         input logic eq, input logic lt, input logic ltu);
    ctrl_t c;
    c = '0;
    case (ph)
      PH_INIT:  c.core_rst = 1;
      PH_FETCH: c.mem_rden1 = 1;
      PH_EXEC:  c = exec_expect(op, f3, f7, eq, lt, ltu);
      PH_WB:    begin c.reg_write = 1; c.rf_wr_sel = 2; c.pc_write = 1; end
      default:  begin c.int_taken = 1; c.pc_write = 1; c.pc_source = 4; end
    endcase
    return c;
  endfunction

  // One clock of stimulus: drive inputs, predict this cycle, advance the model.
  task automatic cycle(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic eq, input logic lt, input logic ltu,
                       input logic intr, input string tag);
    sb_item_t item;
    @(negedge CLK);
    RST          = rst;
    bus.opcode   = op;
    bus.func3    = f3;
    bus.func7_b5 = f7;
    bus.br_eq    = eq;
    bus.br_lt    = lt;
    bus.br_ltu   = ltu;
    bus.intr     = intr;
    item.exp = model_expect(phase, op, f3, f7, eq, lt, ltu);
    item.tag = tag;
    sb.push_back(item);
    if (rst) phase = PH_INIT;
    else begin
      case (phase)
        PH_INIT:  phase = PH_FETCH;
        PH_FETCH: phase = PH_EXEC;
        PH_EXEC:  phase = (op == OP_LOAD) ? PH_WB : (intr ? PH_INTR : PH_FETCH);
        PH_WB:    phase = intr ? PH_INTR : PH_FETCH;
        default:  phase = PH_FETCH;
      endcase
    end
  endtask

  // Whole instruction from fetch until the model is back at fetch.
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic eq, input logic lt, input logic ltu,
                       input logic intr_fetch, input logic intr_done, input string tag);
    cycle(1'b0, op, f3, f7, eq, lt, ltu, intr_fetch, {tag, "_fetch"});
    for (int k = 0; k < 4 && phase != PH_FETCH; k++)
      cycle(1'b0, op, f3, f7, eq, lt, ltu, intr_done, $sformatf("%s_c%0d", tag, k + 1));
  endtask

  // Monitor: compare the DUT to each queued prediction mid-cycle.
  initial begin
    sb_item_t item;
    ctrl_t    got;
    forever begin
      @(negedge CLK);
      #2;
      if (sb.size() != 0) begin
        item = sb.pop_front();
        got  = observed();
        checks++;
        if (got !== item.exp) begin
          failures++;
          $display("FAIL %s: got=%06h required=%06h (t=%0t)", item.tag, got, item.exp, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                 7'b1101111, 7'b1100111, 7'b0100011, 7'b0000011,
                                 7'b1100011, 7'b1110011};

  initial begin
    RST = 1'b1;
    bus.opcode = '0; bus.func3 = '0; bus.func7_b5 = 1'b0;
    bus.br_eq = 1'b0; bus.br_lt = 1'b0; bus.br_ltu = 1'b0; bus.intr = 1'b0;

    cycle(1'b1, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold0");
    cycle(1'b1, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold1");
    cycle(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_release");

    instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "add");
    instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw");
    instr(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bne_eq1");
    instr(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bne_eq0");
    instr(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "addi_intr");
    instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "add_intr_fetch");
    instr(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "srai");
    instr(7'b0010011, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "slli_b30");
    instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sub");
    instr(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lui");
    instr(7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "auipc");
    instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "jal");
    instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "jalr");
    instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sw");
    instr(7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "branch_f3_010");
    instr(7'b1110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mret");
    instr(7'b1110011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "csrrw");
    instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "unknown_op");
    instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "lw_intr");

    cycle(1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw_rst_fetch");
    cycle(1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw_rst_exec");
    cycle(1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw_rst_wb");
    cycle(1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw_rst_init");

    for (int n = 0; n < 1500; n++) begin
      logic [6:0] op;
      logic [31:0] r;
      r  = $urandom;
      op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 9)] : 7'($urandom);
      cycle(($urandom_range(0, 49) == 0), op, r[2:0], r[3], r[4], r[5], r[6], r[7], "rand");
    end

    repeat (3) @(negedge CLK);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got=%0d pending predictions required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
